// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot row drive, per-key debounce,
// small key FIFO with pop handshake, overflow flag and IRQ pulse.
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 3,
  parameter int SCAN_DIV   = 22727,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int IRQ_CYCLES = 3,
  localparam int KW        = $clog2(ROWS*COLS),
  localparam int CW        = $clog2(FIFO_DEPTH+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  input  logic            pop,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic [CW-1:0]   key_count,
  output logic            interrupt,
  output logic            overflow
);

  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int IW  = $clog2(IRQ_CYCLES+1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB_PRESS,
    S_HELD,
    S_DEB_REL
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_div;
  logic            w_tick;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   w_row_nxt;
  logic [RW-1:0]   w_row_inc;
  logic [CLW-1:0]  r_col;
  logic [CLW-1:0]  w_col_nxt;
  logic [CLW-1:0]  w_low;
  logic            w_any;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic [3:0]      w_cnt_inc;
  logic            w_push;
  logic [KW-1:0]   w_push_code;
  logic [KW-1:0]   w_code_held;
  logic [KW-1:0]   w_code_new;

  logic [KW-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   w_rptr_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            w_full;
  logic            w_empty;
  logic            w_do_pop;
  logic            w_do_push;
  logic            w_drop;
  logic [KW-1:0]   r_key_code;
  logic [KW-1:0]   w_head_nxt;
  logic            r_ovf;
  logic [IW-1:0]   r_irq;

  function automatic logic [CLW-1:0] f_lowest(
    input logic [COLS-1:0] v
  );
    logic [CLW-1:0] idx;
    idx = '0;
    for (int i = COLS-1; i >= 0; i--) begin
      if (v[i]) idx = CLW'(i);
    end
    return idx;
  endfunction

  // Scan-tick divider: strobe on the last count, then wrap.
  always_ff @(posedge clk) begin
    if (reset) r_div <= '0;
    else if (w_tick) r_div <= '0;
    else r_div <= r_div + DW'(1);
  end

  assign w_tick = (r_div == DW'(SCAN_DIV-1));

  // Column decode and key-code arithmetic.
  always_comb begin
    w_any       = |col_in;
    w_low       = f_lowest(col_in);
    w_row_inc   = (r_row == RW'(ROWS-1)) ? '0 : r_row + RW'(1);
    w_cnt_inc   = r_cnt + 4'd1;
    w_code_held = KW'(int'(r_row) * COLS + int'(r_col));
    w_code_new  = KW'(int'(r_row) * COLS + int'(w_low));
  end

  // Scan/debounce state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_SCAN;
      r_row   <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; everything moves only on a scan tick.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_push_code = w_code_held;
    if (w_tick) begin
      unique case (r_state)
        S_SCAN: begin
          if (w_any) begin
            w_col_nxt = w_low;
            w_cnt_nxt = 4'd1;
            if (DEBOUNCE == 1) begin
              w_push      = 1'b1;
              w_push_code = w_code_new;
              w_state_nxt = S_HELD;
            end else begin
              w_state_nxt = S_DEB_PRESS;
            end
          end else begin
            w_row_nxt = w_row_inc;
          end
        end
        S_DEB_PRESS: begin
          if (w_any && (w_low == r_col)) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == 4'(DEBOUNCE)) begin
              w_push      = 1'b1;
              w_state_nxt = S_HELD;
            end
          end else begin
            w_cnt_nxt   = '0;
            w_row_nxt   = w_row_inc;
            w_state_nxt = S_SCAN;
          end
        end
        S_HELD: begin
          if (!w_any) begin
            if (DEBOUNCE == 1) begin
              w_cnt_nxt   = '0;
              w_row_nxt   = w_row_inc;
              w_state_nxt = S_SCAN;
            end else begin
              w_cnt_nxt   = 4'd1;
              w_state_nxt = S_DEB_REL;
            end
          end
        end
        S_DEB_REL: begin
          if (!w_any) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == 4'(DEBOUNCE)) begin
              w_row_nxt   = w_row_inc;
              w_state_nxt = S_SCAN;
            end
          end else begin
            w_state_nxt = S_HELD;
          end
        end
        default: begin
          w_state_nxt = S_SCAN;
        end
      endcase
    end
  end

  // One-hot row drive from the row index.
  always_comb begin
    row_out        = '0;
    row_out[r_row] = 1'b1;
  end

  // FIFO control: full+push+pop does both, empty ignores pop.
  always_comb begin
    w_full      = (r_count == CW'(FIFO_DEPTH));
    w_empty     = (r_count == '0);
    w_do_pop    = pop & ~w_empty;
    w_do_push   = w_push & (~w_full | w_do_pop);
    w_drop      = w_push & w_full & ~w_do_pop;
    w_rptr_nxt  = w_do_pop ? r_rptr + PW'(1) : r_rptr;
    w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);
    if (w_count_nxt == '0)
      w_head_nxt = '0;
    else if (w_do_push && (w_count_nxt == CW'(1)))
      w_head_nxt = w_push_code;
    else
      w_head_nxt = r_mem[w_rptr_nxt];
  end

  // Key storage; contents are qualified by the count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= w_push_code;
  end

  // Pointers, occupancy, registered head and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_key_code <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      r_rptr     <= w_rptr_nxt;
      r_count    <= w_count_nxt;
      r_key_code <= w_head_nxt;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Interrupt pulse counter, reloaded by every accepted key.
  always_ff @(posedge clk) begin
    if (reset) r_irq <= '0;
    else if (w_do_push) r_irq <= IW'(IRQ_CYCLES);
    else if (r_irq != '0) r_irq <= r_irq - IW'(1);
  end

  assign key_code  = r_key_code;
  assign key_valid = (r_count != '0);
  assign key_count = r_count;
  assign interrupt = (r_irq != '0);
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random key
// activity, compared cycle by cycle against a tick-level model.
module tb_keypad_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 3;
  localparam int DIV   = 4;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;
  localparam int IRQ   = 3;

  localparam int LOOK    = 0;
  localparam int CONFIRM = 1;
  localparam int DOWN    = 2;
  localparam int LIFT    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pop = 1'b0;
  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_out;
  logic [3:0] key_code;
  logic key_valid;
  logic [2:0] key_count;
  logic interrupt;
  logic overflow;
  logic [ROWS-1:0][COLS-1:0] keys = '0;

  int n_checks = 0;
  int n_errors = 0;
  int irq_hi = 0;
  bit pop_on_push = 1'b0;

  int m_div, m_row, m_phase, m_run, m_col, m_irq;
  bit m_ovf;
  int m_q[$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(DIV),
    .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH), .IRQ_CYCLES(IRQ)
  ) dut (
    .clk(clk), .reset(reset), .col_in(col_in),
    .row_out(row_out), .pop(pop), .key_code(key_code),
    .key_valid(key_valid), .key_count(key_count),
    .interrupt(interrupt), .overflow(overflow)
  );

  // Physical matrix: a closed key shorts its row to its column.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++)
      if (row_out[r]) col_in = col_in | keys[r];
  end

  task automatic check(string tag, int obs, int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lowest(logic [COLS-1:0] v);
    for (int i = 0; i < COLS; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit model_will_push();
    int low;
    if (reset || m_div != DIV-1) return 1'b0;
    low = lowest(keys[m_row]);
    if (m_phase == LOOK) return (DEB == 1) && (low >= 0);
    if (m_phase == CONFIRM) return (low == m_col) && (m_run + 1 == DEB);
    return 1'b0;
  endfunction

  task automatic model_step();
    bit tick, push, popped;
    int low, code;
    if (reset) begin
      m_div = 0; m_row = 0; m_phase = LOOK; m_run = 0; m_col = 0;
      m_q.delete(); m_irq = 0; m_ovf = 1'b0;
      return;
    end
    push = 1'b0;
    code = 0;
    tick = (m_div == DIV-1);
    m_div = tick ? 0 : m_div + 1;
    if (tick) begin
      low = lowest(keys[m_row]);
      case (m_phase)
        LOOK: begin
          if (low >= 0) begin
            m_col = low; m_run = 1;
            if (DEB == 1) begin
              push = 1'b1; code = m_row * COLS + low; m_phase = DOWN;
            end else m_phase = CONFIRM;
          end else m_row = (m_row + 1) % ROWS;
        end
        CONFIRM: begin
          if (low == m_col) begin
            m_run++;
            if (m_run == DEB) begin
              push = 1'b1; code = m_row * COLS + m_col; m_phase = DOWN;
            end
          end else begin
            m_run = 0; m_row = (m_row + 1) % ROWS; m_phase = LOOK;
          end
        end
        DOWN: begin
          if (low < 0) begin
            m_run = 1; m_phase = LIFT;
          end
        end
        default: begin
          if (low < 0) begin
            m_run++;
            if (m_run == DEB) begin
              m_row = (m_row + 1) % ROWS; m_phase = LOOK;
            end
          end else m_phase = DOWN;
        end
      endcase
    end
    popped = pop && (m_q.size() > 0);
    if (push && m_q.size() == DEPTH && !popped) m_ovf = 1'b1;
    if (popped) void'(m_q.pop_front());
    if (push && (m_q.size() < DEPTH)) begin
      m_q.push_back(code);
      m_irq = IRQ;
    end else if (m_irq > 0) m_irq--;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    #1;
    if (pop_on_push) pop = model_will_push();
    model_step();
    @(posedge clk);
    #1;
    check("row_out", int'(row_out), 1 << m_row);
    check("key_valid", int'(key_valid), int'(m_q.size() > 0));
    check("key_count", int'(key_count), m_q.size());
    check("key_code", int'(key_code), (m_q.size() > 0) ? m_q[0] : 0);
    check("interrupt", int'(interrupt), int'(m_irq != 0));
    check("overflow", int'(overflow), int'(m_ovf));
    if (interrupt) irq_hi++;
    @(negedge clk);
    if (pop_on_push) pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic press_key(int r, int c, int hold);
    int k;
    keys[r][c] = 1'b1;
    k = 0;
    while (m_phase != DOWN && k < 300) begin
      cycle(); k++;
    end
    if (k >= 300) check("press_timeout", k, 0);
    repeat (hold) cycle();
    keys[r][c] = 1'b0;
    k = 0;
    while (m_phase != LOOK && k < 300) begin
      cycle(); k++;
    end
    if (k >= 300) check("release_timeout", k, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (m_q.size() > 0 && k < 20) begin
      pop = 1'b1; cycle(); pop = 1'b0; k++;
    end
  endtask

  initial begin
    int k;
    @(negedge clk);
    do_reset();
    check("rst_row", int'(row_out), 1);
    check("rst_valid", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    repeat (4) cycle();
    check("scan_r1", int'(row_out), 2);
    repeat (4) cycle();
    check("scan_r2", int'(row_out), 4);
    repeat (4) cycle();
    check("scan_r3", int'(row_out), 8);
    repeat (4) cycle();
    check("scan_wrap", int'(row_out), 1);

    irq_hi = 0;
    press_key(2, 1, 2);
    check("key7_code", int'(key_code), 7);
    check("key7_count", int'(key_count), 1);
    check("key7_irq_len", irq_hi, 3);
    drain();
    check("pop_empty", int'(key_valid), 0);

    k = 0;
    while (!(m_row == 1 && m_div == 0) && k < 40) begin
      cycle(); k++;
    end
    keys[1][0] = 1'b1;
    repeat (4) cycle();
    keys[1][0] = 1'b0;
    repeat (4) cycle();
    check("glitch_row", int'(row_out), 4);
    check("glitch_count", int'(key_count), 0);

    press_key(0, 2, 80);
    check("hold_count", int'(key_count), 1);
    check("hold_code", int'(key_code), 2);
    repeat (8) cycle();
    drain();

    press_key(0, 1, 1);
    press_key(1, 1, 1);
    press_key(2, 2, 1);
    press_key(3, 0, 1);
    press_key(1, 2, 1);
    check("ovf_count", int'(key_count), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_head", int'(key_code), 1);

    keys[2][0] = 1'b1;
    k = 0;
    while (m_phase != CONFIRM && k < 60) begin
      cycle(); k++;
    end
    do_reset();
    keys[2][0] = 1'b0;
    check("mid_rst_row", int'(row_out), 1);
    check("mid_rst_valid", int'(key_valid), 0);
    check("mid_rst_count", int'(key_count), 0);
    check("mid_rst_ovf", int'(overflow), 0);
    check("mid_rst_irq", int'(interrupt), 0);
    repeat (20) cycle();

    press_key(0, 0, 1);
    press_key(1, 0, 1);
    press_key(2, 0, 1);
    press_key(3, 1, 1);
    pop_on_push = 1'b1;
    press_key(0, 1, 1);
    pop_on_push = 1'b0;
    check("pp_count", int'(key_count), 4);
    check("pp_ovf", int'(overflow), 0);
    check("pp_head", int'(key_code), 3);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom % 24 == 0) begin
        keys = '0;
        case ($urandom % 4)
          1: keys[$urandom % ROWS][$urandom % COLS] = 1'b1;
          2: begin
            k = $urandom % ROWS;
            keys[k][$urandom % COLS] = 1'b1;
            keys[k][$urandom % COLS] = 1'b1;
          end
          3: begin
            keys[$urandom % ROWS][$urandom % COLS] = 1'b1;
            keys[$urandom % ROWS][$urandom % COLS] = 1'b1;
          end
          default: keys = '0;
        endcase
      end
      pop = ($urandom % 6 == 0);
      reset = ($urandom % 800 == 0);
      cycle();
    end
    pop = 1'b0;
    reset = 1'b0;
    keys = '0;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
